// File: rtl/nibble_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_bus_master
//  Purpose  : Bus initiator for the 4-bit shared-bus nibble RAM. Accepts
//             single/multi-nibble read and write bursts over valid/ready,
//             sequences one nibble per cycle, and assembles read nibbles
//             into a little-endian response word.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_bus_master #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MAX_NIBBLES = 4,
  parameter int LEN_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [LEN_WIDTH-1:0]     req_len,
  input  logic [4*MAX_NIBBLES-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic [4*MAX_NIBBLES-1:0] rsp_rdata,
  output logic                     busy,
  output logic [ADDR_WIDTH-1:0]    mem_address,
  inout  wire  [3:0]               mem_data_bus,
  output logic                     mem_write_enable,
  output logic                     mem_read_enable
);

  localparam int DATA_WIDTH = 4 * MAX_NIBBLES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_n;
  logic [LEN_WIDTH-1:0]    len_q, len_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0]   wdata_shift;
  logic [3:0]              wnib_q, wnib_n;
  logic                    we_q, we_n;
  logic                    re_q, re_n;
  logic                    rspv_q, rspv_n;
  // Read capture happens one cycle after the address is issued, so the
  // nibble index to fill is carried across the posedge into the negedge domain.
  logic                    cap_en_q, cap_en_n;
  logic [LEN_WIDTH-1:0]    cap_idx_q, cap_idx_n;
  // Clearing of unused upper nibbles is requested at accept and applied
  // by the negedge capture register in the first READ cycle.
  logic                    clr_en_q, clr_en_n;
  logic [LEN_WIDTH-1:0]    clr_len_q, clr_len_n;
  logic [DATA_WIDTH-1:0]   keep_mask;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;

  // Next-state and next-output logic; every control output is registered.
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    cnt_n       = cnt_q;
    len_n       = len_q;
    wdata_n     = wdata_q;
    wnib_n      = wnib_q;
    wdata_shift = '0;
    we_n        = 1'b0;
    re_n        = 1'b0;
    rspv_n      = 1'b0;
    cap_en_n    = 1'b0;
    cap_idx_n   = cnt_q;
    clr_en_n    = 1'b0;
    clr_len_n   = clr_len_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_n  = req_addr;
          len_n   = req_len;
          wdata_n = req_wdata;
          cnt_n   = '0;
          if (req_write) begin
            state_n = S_WRITE;
            we_n    = 1'b1;
            wnib_n  = req_wdata[3:0];
          end else begin
            state_n   = S_READ;
            re_n      = 1'b1;
            clr_en_n  = 1'b1;
            clr_len_n = req_len;
          end
        end
      end
      S_WRITE: begin
        if (cnt_q == len_q) begin
          state_n = S_RESP;
          rspv_n  = 1'b1;
        end else begin
          cnt_n       = cnt_q + 1'b1;
          addr_n      = addr_q + 1'b1;
          wdata_shift = wdata_q >> {cnt_n, 2'b00};
          wnib_n      = wdata_shift[3:0];
          we_n        = 1'b1;
        end
      end
      S_READ: begin
        cap_en_n  = 1'b1;
        cap_idx_n = cnt_q;
        if (cnt_q == len_q) begin
          state_n = S_DRAIN;
        end else begin
          cnt_n  = cnt_q + 1'b1;
          addr_n = addr_q + 1'b1;
          re_n   = 1'b1;
        end
      end
      S_DRAIN: begin
        state_n = S_RESP;
        rspv_n  = 1'b1;
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and registered control outputs; reset aborts any burst silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      wnib_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rspv_q    <= 1'b0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      clr_en_q  <= 1'b0;
      clr_len_q <= '0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      cnt_q     <= cnt_n;
      len_q     <= len_n;
      wdata_q   <= wdata_n;
      wnib_q    <= wnib_n;
      we_q      <= we_n;
      re_q      <= re_n;
      rspv_q    <= rspv_n;
      cap_en_q  <= cap_en_n;
      cap_idx_q <= cap_idx_n;
      clr_en_q  <= clr_en_n;
      clr_len_q <= clr_len_n;
    end
  end

  // Mask keeping nibbles 0..len of the response; higher ones start at zero.
  always_comb begin
    keep_mask = '0;
    for (int j = 0; j < MAX_NIBBLES; j++) begin
      keep_mask[4*j +: 4] = (LEN_WIDTH'(j) <= clr_len_q) ? 4'hF : 4'h0;
    end
  end

  // Next value of the read-assembly register: clear, then drop in the nibble.
  always_comb begin
    rdata_n = rdata_q;
    if (clr_en_q) begin
      rdata_n = rdata_q & keep_mask;
    end
    if (cap_en_q) begin
      rdata_n[{cap_idx_q, 2'b00} +: 4] = mem_data_bus;
    end
  end

  // The RAM drives its nibble during the high phase, so sample on the negedge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_n;
    end
  end

  assign req_ready        = (state == S_IDLE) && !reset;
  assign busy             = (state != S_IDLE);
  assign rsp_valid        = rspv_q;
  assign rsp_rdata        = rdata_q;
  assign mem_address      = addr_q;
  assign mem_write_enable = we_q;
  assign mem_read_enable  = re_q;
  // Only the registered write strobe grants bus ownership to the master.
  assign mem_data_bus     = we_q ? wnib_q : 4'bz;

endmodule
`default_nettype wire
